// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked shift of
// 8 data bits + odd parity + stop, then ACK check; every device-clocked phase is timed out.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  // Handshake: a byte is taken on any clk edge where tx_valid && tx_ready; tx_ready is high
  // only in IDLE, and exactly one of tx_done/tx_err pulses for one cycle per accepted byte.
  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE} state_t;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [1:0]       clk_sync, data_sync;
  logic             clk_prev;
  logic             clk_s, data_s, fall;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             parity, parity_next;
  logic [3:0]       bit_idx, bit_idx_next;
  logic             data_low_q, data_low_next;
  logic             cur_bit;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_prev & ~clk_s;

  // Idle bus level is high, so synchronizers reset to 1 to avoid a phantom fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_reg  <= '0;
      parity     <= 1'b0;
      bit_idx    <= '0;
      data_low_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      shift_reg  <= shift_next;
      parity     <= parity_next;
      bit_idx    <= bit_idx_next;
      data_low_q <= data_low_next;
    end
  end

  // Bit driven on the fall with index bit_idx: 0..7 data LSB first, 8 parity, 9 stop.
  always_comb begin
    cur_bit = 1'b1;
    if (bit_idx < 4'd8)       cur_bit = shift_reg[bit_idx[2:0]];
    else if (bit_idx == 4'd8) cur_bit = parity;
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    shift_next    = shift_reg;
    parity_next   = parity;
    bit_idx_next  = bit_idx;
    data_low_next = data_low_q;
    ps2_clk_low   = 1'b0;
    ps2_data_low  = 1'b0;
    tx_ready      = 1'b0;
    tx_done       = 1'b0;
    tx_err        = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          shift_next    = tx_data;
          parity_next   = ~^tx_data;
          cnt_next      = '0;
          bit_idx_next  = '0;
          data_low_next = 1'b0;
          state_next    = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_low = 1'b1;
        if (cnt == INH_LAST) begin
          ps2_data_low  = 1'b1;
          data_low_next = 1'b1;
          cnt_next      = '0;
          state_next    = SEND;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      SEND: begin
        ps2_data_low = data_low_q;
        if (fall) begin
          cnt_next      = '0;
          data_low_next = ~cur_bit;
          bit_idx_next  = bit_idx + 4'd1;
          if (bit_idx == 4'd9) state_next = ACK;
        end else if (cnt == TO_LAST) begin
          ps2_data_low  = 1'b0;
          data_low_next = 1'b0;
          tx_err        = 1'b1;
          state_next    = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ACK: begin
        if (fall) begin
          cnt_next = '0;
          if (!data_s) begin
            state_next = WAIT_IDLE;
          end else begin
            tx_err     = 1'b1;
            state_next = IDLE;
          end
        end else if (cnt == TO_LAST) begin
          tx_err     = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end else if (fall) begin
          cnt_next = '0;
        end else if (cnt == TO_LAST) begin
          tx_err     = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
